// File: rtl/tetris_pkg.sv
// Shared command codes, PS2 scan constants, FSM states and the key map
// used by the Tetris move scheduler.
package tetris_pkg;

  localparam int unsigned CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_NOP       = 3'd0;
  localparam logic [CMD_W-1:0] CMD_LEFT      = 3'd1;
  localparam logic [CMD_W-1:0] CMD_RIGHT     = 3'd2;
  localparam logic [CMD_W-1:0] CMD_ROTATE    = 3'd3;
  localparam logic [CMD_W-1:0] CMD_DOWN      = 3'd4;
  localparam logic [CMD_W-1:0] CMD_HARD_DROP = 3'd5;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ISSUE  = 2'd2
  } state_e;

  typedef struct packed {
    logic             hit;
    logic [CMD_W-1:0] code;
  } key_map_t;

  // Make-code to move command; prefix/break bytes and unknown keys never hit.
  function automatic key_map_t map_scan(input logic [7:0] sc);
    key_map_t m;
    m.hit  = 1'b1;
    m.code = CMD_NOP;
    case (sc)
      SC_LEFT:  m.code = CMD_LEFT;
      SC_RIGHT: m.code = CMD_RIGHT;
      SC_UP:    m.code = CMD_ROTATE;
      SC_DOWN:  m.code = CMD_DOWN;
      SC_SPACE: m.code = CMD_HARD_DROP;
      SC_EXT:   m.hit  = 1'b0;
      SC_BREAK: m.hit  = 1'b0;
      default:  m.hit  = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Small synchronous FIFO of move codes with flush; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module move_fifo
  import tetris_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CMD_W-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tetris_move_scheduler.sv
// Arbitrates PS2 key moves and gravity ticks into a single valid/ready
// command stream for the board logic; gravity wins over queued keys.
module tetris_move_scheduler
  import tetris_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned CNT_W    = 26
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [7:0]       key_data,
  input  logic             key_pressed,
  input  logic             game_active,
  input  logic             game_over,
  input  logic [3:0]       level,
  output logic             cmd_valid,
  output logic [CMD_W-1:0] cmd_code,
  input  logic             cmd_ready,
  output logic             cmd_is_gravity,
  output logic             key_dropped,
  output logic [2:0]       fifo_count
);

  localparam int unsigned FCW = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] TICK_BASE = CNT_W'(TICK_DIV);

  state_e           state;
  logic             brk;
  logic             tick_pending;
  logic [CNT_W-1:0] grav_cnt;
  logic [CNT_W-1:0] shifted_c;
  logic [CNT_W-1:0] period_c;
  logic [CNT_W-1:0] last_c;
  logic [2:0]       lvl_c;
  key_map_t         map_c;
  logic             pause_c;
  logic             running_c;
  logic             wrap_c;
  logic             push_c;
  logic             pop_c;
  logic             full_c;
  logic             empty_c;
  logic [CMD_W-1:0] head_c;
  logic [FCW-1:0]   count_c;

  assign pause_c   = !game_active || game_over;
  assign running_c = (state != ST_PAUSED) && !pause_c;

  // Gravity period: base shifted by a level saturated at 7, never below 1.
  assign lvl_c     = (level > 4'd7) ? 3'd7 : level[2:0];
  assign shifted_c = TICK_BASE >> lvl_c;
  assign period_c  = (shifted_c == '0) ? CNT_W'(1) : shifted_c;
  assign last_c    = period_c - CNT_W'(1);
  assign wrap_c    = running_c && (grav_cnt >= last_c);

  assign map_c  = map_scan(key_data);
  assign push_c = key_pressed && !brk && map_c.hit && !pause_c;
  assign pop_c  = (state == ST_IDLE) && !pause_c && !tick_pending && !empty_c;

  move_fifo #(
    .DEPTH (QDEPTH),
    .CW    (FCW)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push_c),
    .push_data (map_c.code),
    .pop       (pop_c),
    .flush     (pause_c),
    .head      (head_c),
    .full      (full_c),
    .empty     (empty_c),
    .count     (count_c)
  );

  assign fifo_count = 3'(count_c);

  // Break-code tracking and gravity counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      brk         <= 1'b0;
      grav_cnt    <= '0;
      key_dropped <= 1'b0;
    end else begin
      key_dropped <= push_c && full_c && !pop_c;
      if (pause_c) begin
        brk <= 1'b0;
      end else if (key_pressed) begin
        if (key_data == SC_BREAK) brk <= 1'b1;
        else if (brk)             brk <= 1'b0;
      end
      if (!running_c || wrap_c) grav_cnt <= '0;
      else                      grav_cnt <= grav_cnt + CNT_W'(1);
    end
  end

  // Command FSM with registered handshake outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_PAUSED;
      tick_pending   <= 1'b0;
      cmd_valid      <= 1'b0;
      cmd_code       <= CMD_NOP;
      cmd_is_gravity <= 1'b0;
    end else if (pause_c) begin
      state          <= ST_PAUSED;
      tick_pending   <= 1'b0;
      cmd_valid      <= 1'b0;
      cmd_code       <= CMD_NOP;
      cmd_is_gravity <= 1'b0;
    end else begin
      if (wrap_c) tick_pending <= 1'b1;
      case (state)
        ST_PAUSED: state <= ST_IDLE;
        ST_IDLE: begin
          if (tick_pending) begin
            if (!wrap_c) tick_pending <= 1'b0;
            cmd_code       <= CMD_DOWN;
            cmd_is_gravity <= 1'b1;
            cmd_valid      <= 1'b1;
            state          <= ST_ISSUE;
          end else if (!empty_c) begin
            cmd_code       <= head_c;
            cmd_is_gravity <= 1'b0;
            cmd_valid      <= 1'b1;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid      <= 1'b0;
            cmd_code       <= CMD_NOP;
            cmd_is_gravity <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_PAUSED;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Directed bench for tetris_move_scheduler: key commands checked through a
// scoreboard queue, gravity commands through handshake timestamps.
module tb_tetris_move_scheduler;
  import tetris_pkg::*;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       key_pressed = 1'b0;
  logic       game_active = 1'b0;
  logic       game_over = 1'b0;
  logic [3:0] level = 4'd0;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready = 1'b0;
  logic       cmd_is_gravity;
  logic       key_dropped;
  logic [2:0] fifo_count;

  tetris_move_scheduler #(
    .TICK_DIV (64),
    .QDEPTH   (4),
    .CNT_W    (8)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .key_data       (key_data),
    .key_pressed    (key_pressed),
    .game_active    (game_active),
    .game_over      (game_over),
    .level          (level),
    .cmd_valid      (cmd_valid),
    .cmd_code       (cmd_code),
    .cmd_ready      (cmd_ready),
    .cmd_is_gravity (cmd_is_gravity),
    .key_dropped    (key_dropped),
    .fifo_count     (fifo_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int drops = 0;
  logic [2:0] exp_q[$];
  int grav_t[$];
  int key_t[$];
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic pg = 1'b0;
  logic [2:0] pc = 3'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Handshake monitor: pops the scoreboard for key commands.
  always @(negedge clock) begin
    if (resetn) begin
      if (key_dropped) drops++;
      if (!cmd_valid) check("nop_when_invalid", 32'(cmd_code), 32'(CMD_NOP));
      if (pv && !pr && cmd_valid) begin
        check("hold_code", 32'(cmd_code), 32'(pc));
        check("hold_grav", 32'(cmd_is_gravity), 32'(pg));
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_is_gravity) begin
          check("grav_code", 32'(cmd_code), 32'(CMD_DOWN));
          grav_t.push_back(cyc);
        end else begin
          check("key_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("key_code", 32'(cmd_code), 32'(exp_q.pop_front()));
          key_t.push_back(cyc);
        end
      end
    end
    pv <= cmd_valid && resetn;
    pr <= cmd_ready;
    pc <= cmd_code;
    pg <= cmd_is_gravity;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic key(input logic [7:0] b);
    key_data    = b;
    key_pressed = 1'b1;
    step();
    key_pressed = 1'b0;
  endtask

  // One paused cycle restarts the gravity counter from zero.
  task automatic resume(output int c0);
    game_active = 1'b0;
    step();
    game_active = 1'b1;
    c0 = cyc;
  endtask

  initial begin
    int c0;
    int d0;
    logic [7:0] burst [6];
    burst = '{SC_LEFT, SC_RIGHT, SC_UP, SC_DOWN, SC_SPACE, SC_LEFT};

    step(2);
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_code", 32'(cmd_code), 32'd0);
    check("rst_grav", 32'(cmd_is_gravity), 32'd0);
    check("rst_drop", 32'(key_dropped), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    resetn = 1'b1;
    step(2);
    check("paused_valid", 32'(cmd_valid), 32'd0);

    // Gravity only, period 8.
    level = 4'd3;
    cmd_ready = 1'b1;
    resume(c0);
    step(40);
    check("grav_first", 32'(grav_t[0]), 32'(c0 + 10));
    check("grav_gap1", 32'(grav_t[1] - grav_t[0]), 32'd8);
    check("grav_gap2", 32'(grav_t[2] - grav_t[1]), 32'd8);
    check("grav_n", 32'(grav_t.size()), 32'd4);
    check("grav_no_keys", 32'(key_t.size()), 32'd0);

    // Make, break and extended sequences.
    level = 4'd0;
    grav_t.delete();
    resume(c0);
    step(2);
    c0 = cyc;
    exp_q.push_back(CMD_LEFT);
    key(SC_LEFT);
    step(2);
    key(SC_BREAK);
    key(SC_LEFT);
    step(2);
    key(SC_EXT);
    exp_q.push_back(CMD_RIGHT);
    key(SC_RIGHT);
    step(10);
    check("dec_latency", 32'(key_t[0]), 32'(c0 + 2));
    check("dec_count", 32'(key_t.size()), 32'd2);
    check("dec_q_empty", 32'(exp_q.size()), 32'd0);
    check("dec_no_grav", 32'(grav_t.size()), 32'd0);

    // Back-pressure with overflow.
    key_t.delete();
    cmd_ready = 1'b0;
    resume(c0);
    step(2);
    d0 = drops;
    for (int i = 0; i < 5; i++) exp_q.push_back(map_scan(burst[i]).code);
    key_pressed = 1'b1;
    for (int i = 0; i < 6; i++) begin
      key_data = burst[i];
      step();
    end
    key_pressed = 1'b0;
    step(3);
    check("bp_count", 32'(fifo_count), 32'd4);
    check("bp_valid", 32'(cmd_valid), 32'd1);
    check("bp_code", 32'(cmd_code), 32'(CMD_LEFT));
    check("bp_drops", 32'(drops - d0), 32'd1);
    cmd_ready = 1'b1;
    step(20);
    check("bp_q_empty", 32'(exp_q.size()), 32'd0);
    check("bp_n", 32'(key_t.size()), 32'd5);
    check("bp_drain", 32'(fifo_count), 32'd0);

    // Tick wrap coincides with a ROTATE push.
    level = 4'd3;
    grav_t.delete();
    key_t.delete();
    resume(c0);
    step(8);
    exp_q.push_back(CMD_ROTATE);
    key(SC_UP);
    step(6);
    check("prio_grav", 32'(grav_t[0]), 32'(c0 + 10));
    check("prio_key", 32'(key_t[0]), 32'(c0 + 12));

    // Level scaling and saturation.
    level = 4'd4;
    grav_t.delete();
    resume(c0);
    step(20);
    check("lvl4_first", 32'(grav_t[0]), 32'(c0 + 6));
    check("lvl4_gap", 32'(grav_t[1] - grav_t[0]), 32'd4);
    level = 4'd12;
    grav_t.delete();
    resume(c0);
    step(20);
    check("lvl12_first", 32'(grav_t[0]), 32'(c0 + 3));
    check("lvl12_gap", 32'(grav_t[1] - grav_t[0]), 32'd2);
    check("lvl12_coalesce", 32'(grav_t.size()), 32'd9);

    // Game over abandons the presented command and flushes the queue.
    level = 4'd0;
    cmd_ready = 1'b0;
    key_t.delete();
    resume(c0);
    step(2);
    key_pressed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      key_data = burst[i];
      step();
    end
    key_pressed = 1'b0;
    step(2);
    check("go_pre_count", 32'(fifo_count), 32'd3);
    check("go_pre_valid", 32'(cmd_valid), 32'd1);
    game_over = 1'b1;
    step();
    check("go_valid", 32'(cmd_valid), 32'd0);
    check("go_count", 32'(fifo_count), 32'd0);
    check("go_code", 32'(cmd_code), 32'd0);
    game_over = 1'b0;
    cmd_ready = 1'b1;
    step(10);
    check("go_no_retry", 32'(key_t.size()), 32'd0);

    // Asynchronous reset while a command is presented.
    cmd_ready = 1'b0;
    resume(c0);
    step(2);
    key(SC_LEFT);
    key(SC_RIGHT);
    step(2);
    check("ar_pre_valid", 32'(cmd_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_valid", 32'(cmd_valid), 32'd0);
    check("ar_code", 32'(cmd_code), 32'd0);
    check("ar_grav", 32'(cmd_is_gravity), 32'd0);
    check("ar_drop", 32'(key_dropped), 32'd0);
    check("ar_count", 32'(fifo_count), 32'd0);
    step(2);
    resetn = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
